ic_sneg_cmp_skolem_serial: RTL and testbench
============================================

// Module: ic_sneg_cmp_skolem_serial
// PURPOSE
//  Bit-serial, parametrised Skolem witness generator for the invertibility condition of
//  (-x) <op> t, with <op> one of signed >, >=, <, <= (the four modes).
//  Given a W-bit t and a mode, it produces a witness x and a sat flag that is high exactly
//  when the condition holds. The witness is generated and then self-checked LSB-first over W cycles.
//  It is a sequential replacement for the per-width combinational skolem netlists and
//  sits behind the solver front-end on a valid/ready stream.
// PARAMETERS
//  W      8                   bit-vector width, >= 2
//  CNT_W  $clog2(W) (derived) bit-index counter width; not overridable
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  request valid
//  in_ready   out  1  block can accept a request (high only in IDLE)
//  in_t       in   W  operand t (two's complement)
//  in_mode    in   2  00 SGT, 01 SGE, 10 SLT, 11 SLE
//  out_valid  out  1  result valid; held until consumed
//  out_ready  in   1  consumer accepts result
//  out_x      out  W  witness x
//  out_neg_x  out  W  -x mod 2^W, computed serially (for checking)
//  out_sat    out  1  1 iff (-x) <op> t holds for out_x (equals the IC)
//  busy       out  1  high in SHIFT or DONE
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0, busy=0; out_x/out_neg_x/out_sat=0;
//    carries, compare flags and bit counter are cleared.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    - IDLE: accept on in_valid&&in_ready (cycle c). Latch t and mode, clear the counter,
//      preload carries per mode, go to SHIFT.
//    - SHIFT: process bit i on cycle c+1+i, i=0..W-1. After i=W-1 go to DONE.
//    - DONE: out_valid=1 from cycle c+W+1. On out_valid&&out_ready go to IDLE, and in_ready
//      is high the next cycle. No overlap between transactions.
//    - Minimum period: W+2 cycles.
//  - Witness x = ~t + K mod 2^W, with K: SGT 0, SGE 1, SLE 1, SLT 2. So:
//    - SGT: -x = t+1.
//    - SGE/SLE: x = -t.
//    - SLT: -x = t-1.
//  - Serial add per bit: xb = ~t[i] ^ K[i] ^ c1, c1 = maj(~t[i], K[i], c1), c1 starts 0. Carry out of the MSB is dropped.
//  - Serial negate: nb = ~xb ^ c2, c2 = ~xb & c2, c2 starts 1. Carry out of the MSB is dropped.
//  - Serial signed compare of nb vs t[i]:
//    - eq &= (nb==t[i]).
//    - For i<W-1, on a bit mismatch: lt = ~nb & t[i].
//    - At i=W-1, on a mismatch: lt = nb (the sign bit decides).
//    - sat = SGT: ~lt&~eq; SGE: ~lt; SLT: lt; SLE: lt|eq. Registered when entering DONE.
//  - Boundaries:
//    - SGT, t=SMAX: x=SMIN, sat=0.
//    - SLT, t=SMIN: x=SMIN+1, sat=0.
//    - SGE and SLE: always sat=1, including t=SMIN (-SMIN wraps to SMIN).
//  - out_x, out_neg_x and out_sat are stable for the whole of DONE. in_t/in_mode are ignored
//    outside the accept cycle.
//  - Reset mid-SHIFT or mid-DONE: the transaction is abandoned, no out_valid is produced,
//    and the block is in IDLE on the next cycle.
//  - Shift registers for t, x and neg_x are W bits, LSB-first. The counter wraps only via the FSM.
// STRUCTURE
//  - skolem_pkg: typedef enum {MODE_SGT,MODE_SGE,MODE_SLT,MODE_SLE} sk_mode_t (2b);
//    typedef enum {ST_IDLE,ST_SHIFT,ST_DONE} sk_state_t; function mode_k(sk_mode_t) -> 2b K;
//    function sat_of(mode,lt,eq).
//  - Sub-module sneg_serial_cmp: per-bit add-K, negate and signed-compare datapath with
//    carries c1/c2 and flags lt/eq; inputs bit i, is_msb, clear. Top owns the FSM, counter,
//    shift registers and handshake.
// TESTING (W=8)
//  1 SGT t=0x05 -> out_x=0xFA, out_neg_x=0x06, sat=1; out_valid exactly 9 cycles after accept.
//  2 SGT t=0x7F -> x=0x80, neg_x=0x80, sat=0; SLT t=0x80 -> x=0x81, neg_x=0x7F, sat=0.
//  3 SLT t=0x10 -> x=0xF1, neg_x=0x0F, sat=1; SLE t=0x80 -> x=0x80, neg_x=0x80, sat=1.
//  4 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0,
//    in_valid ignored; release -> in_ready=1 next cycle.
//  5 Assert rst at cycle 3 of SHIFT -> no out_valid; all outputs 0; in_ready=1 the cycle
//    after rst falls; the next request (SGE t=0x01 -> x=0xFF, sat=1) completes correctly.
//  6 Random sweep, W=4 exhaustive over t and mode, back-to-back requests: sat must match
//    t!=SMAX (SGT), t!=SMIN (SLT), 1 (SGE/SLE), and neg_x must equal -x.

Source files
------------

// File: rtl/skolem_pkg.sv
// Shared types and helpers for the bit-serial Skolem witness generator of (-x) <op> t.
package skolem_pkg;

  typedef enum logic [1:0] {
    MODE_SGT = 2'b00,
    MODE_SGE = 2'b01,
    MODE_SLT = 2'b10,
    MODE_SLE = 2'b11
  } sk_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sk_state_t;

  // Constant K added to ~t so that x = ~t + K gives the witness for each mode.
  function automatic logic [1:0] mode_k(input sk_mode_t mode);
    case (mode)
      MODE_SGT: return 2'd0;
      MODE_SLT: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

  function automatic logic sat_of(input sk_mode_t mode, input logic lt, input logic eq);
    case (mode)
      MODE_SGT: return ~lt & ~eq;
      MODE_SGE: return ~lt;
      MODE_SLT: return lt;
      default:  return lt | eq;
    endcase
  endfunction

endpackage

// File: rtl/sneg_serial_cmp.sv
// One-bit-per-cycle datapath: x = ~t + K, nb = -x, and signed compare of -x against t, LSB-first.
module sneg_serial_cmp (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic t_bit,
  input  logic k_bit,
  input  logic is_msb,
  output logic xb,
  output logic nb,
  output logic lt_next,
  output logic eq_next
);

  logic c1;
  logic c2;
  logic lt;
  logic eq;
  logic nt;

  assign nt      = ~t_bit;
  assign xb      = nt ^ k_bit ^ c1;
  assign nb      = ~xb ^ c2;
  assign eq_next = eq & (nb == t_bit);

  // A higher mismatching bit overrides lower ones; at the sign bit the meaning of a 1 flips.
  always_comb begin
    lt_next = lt;
    if (nb != t_bit) begin
      lt_next = is_msb ? nb : (~nb & t_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c1 <= 1'b0;
      c2 <= 1'b0;
      lt <= 1'b0;
      eq <= 1'b0;
    end else if (clear) begin
      c1 <= 1'b0;
      c2 <= 1'b1;
      lt <= 1'b0;
      eq <= 1'b1;
    end else if (en) begin
      c1 <= (nt & k_bit) | (nt & c1) | (k_bit & c1);
      c2 <= ~xb & c2;
      lt <= lt_next;
      eq <= eq_next;
    end
  end

endmodule

// File: rtl/ic_sneg_cmp_skolem_serial.sv
// Bit-serial Skolem witness generator for (-x) <op> t behind a valid/ready request/response stream.
module ic_sneg_cmp_skolem_serial
  import skolem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_t,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_neg_x,
  output logic         out_sat,
  output logic         busy
);

  localparam int CNT_W = $clog2(W);

  sk_state_t        state;
  sk_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     t_sr;
  logic [W-1:0]     x_sr;
  logic [W-1:0]     nx_sr;
  sk_mode_t         mode_r;
  logic             sat_r;
  logic [1:0]       k_val;
  logic             k_bit;
  logic             is_msb;
  logic             accept;
  logic             xb;
  logic             nb;
  logic             lt_next;
  logic             eq_next;

  assign accept = (state == ST_IDLE) && in_valid;
  assign is_msb = (cnt == CNT_W'(W - 1));
  assign k_val  = mode_k(mode_r);
  // K only has two bits; all higher addend bits are zero.
  assign k_bit  = (cnt == CNT_W'(0)) ? k_val[0] :
                  (cnt == CNT_W'(1)) ? k_val[1] : 1'b0;

  sneg_serial_cmp u_cmp (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (state == ST_SHIFT),
    .t_bit   (t_sr[0]),
    .k_bit   (k_bit),
    .is_msb  (is_msb),
    .xb      (xb),
    .nb      (nb),
    .lt_next (lt_next),
    .eq_next (eq_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (is_msb) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result bits enter at the MSB end so bit i lands at position i after W shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      t_sr   <= '0;
      x_sr   <= '0;
      nx_sr  <= '0;
      mode_r <= MODE_SGT;
      sat_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            t_sr   <= in_t;
            mode_r <= sk_mode_t'(in_mode);
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          t_sr  <= {1'b0, t_sr[W-1:1]};
          x_sr  <= {xb, x_sr[W-1:1]};
          nx_sr <= {nb, nx_sr[W-1:1]};
          if (is_msb) begin
            cnt   <= '0;
            sat_r <= sat_of(mode_r, lt_next, eq_next);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_x     = x_sr;
  assign out_neg_x = nx_sr;
  assign out_sat   = sat_r;

endmodule

// File: tb/tb_ic_sneg_cmp_skolem_serial.sv
// Directed self-checking bench: W=8 instance for directed vectors, W=4 instance for an exhaustive sweep.
module tb_ic_sneg_cmp_skolem_serial;
  import skolem_pkg::*;

  logic       clk;
  logic       rst;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_t;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic [7:0] out_neg_x;
  logic       out_sat;
  logic       busy;

  logic       in_valid4;
  logic       in_ready4;
  logic [3:0] in_t4;
  logic [1:0] in_mode4;
  logic       out_valid4;
  logic       out_ready4;
  logic [3:0] out_x4;
  logic [3:0] out_neg_x4;
  logic       out_sat4;
  logic       busy4;

  int compared;
  int mismatched;

  ic_sneg_cmp_skolem_serial #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_t      (in_t),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_neg_x (out_neg_x),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  ic_sneg_cmp_skolem_serial #(.W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_t      (in_t4),
    .in_mode   (in_mode4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_x     (out_x4),
    .out_neg_x (out_neg_x4),
    .out_sat   (out_sat4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one request on the W=8 instance and waits (bounded) for out_valid; returns the latency.
  task automatic applyStimulus(input logic [7:0] t, input logic [1:0] mode, output int lat);
    in_t     = t;
    in_mode  = mode;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_t     = ~t;
    in_mode  = ~mode;
    checkOutput("busy_in_shift", busy, 1'b1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic runTxn(input string tag, input logic [7:0] t, input logic [1:0] mode,
                        input logic [7:0] ex, input logic [7:0] enx, input logic es);
    int lat;
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    applyStimulus(t, mode, lat);
    checkOutput({tag, "_latency"}, lat, 9);
    checkOutput({tag, "_x"}, out_x, ex);
    checkOutput({tag, "_neg_x"}, out_neg_x, enx);
    checkOutput({tag, "_sat"}, out_sat, es);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, in_ready, 1'b1);
    checkOutput({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  // Every (mode, t) pair on the 4-bit instance, consumer always ready, requests issued back to back.
  task automatic sweep4();
    logic [3:0] tt;
    logic [3:0] k;
    logic [3:0] xe;
    logic [3:0] ne;
    logic       se;
    int         n;
    out_ready4 = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int t = 0; t < 16; t++) begin
        tt = 4'(t);
        k  = (m == 0) ? 4'd0 : (m == 2) ? 4'd2 : 4'd1;
        xe = ~tt + k;
        ne = 4'd0 - xe;
        se = (m == 0) ? (tt != 4'h7) : (m == 2) ? (tt != 4'h8) : 1'b1;
        in_t4     = tt;
        in_mode4  = 2'(m);
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        n = 1;
        while (!out_valid4 && n < 20) begin
          step();
          n++;
        end
        checkOutput($sformatf("w4_lat_m%0d_t%0h", m, t), n, 5);
        checkOutput($sformatf("w4_x_m%0d_t%0h", m, t), out_x4, xe);
        checkOutput($sformatf("w4_negx_m%0d_t%0h", m, t), out_neg_x4, ne);
        checkOutput($sformatf("w4_sat_m%0d_t%0h", m, t), out_sat4, se);
        step();
      end
    end
    out_ready4 = 1'b0;
  endtask

  initial begin
    int   lat;
    logic seen_valid;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_t       = 8'h00;
    in_mode    = 2'b00;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    in_t4      = 4'h0;
    in_mode4   = 2'b00;
    out_ready4 = 1'b0;
    step();
    step();

    // Reset state
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_x", out_x, 8'h00);
    checkOutput("rst_neg_x", out_neg_x, 8'h00);
    checkOutput("rst_sat", out_sat, 1'b0);
    rst = 1'b0;
    step();

    // Directed vectors, hand-computed
    runTxn("sgt_05", 8'h05, 2'b00, 8'hFA, 8'h06, 1'b1);
    runTxn("sgt_smax", 8'h7F, 2'b00, 8'h80, 8'h80, 1'b0);
    runTxn("slt_smin", 8'h80, 2'b10, 8'h81, 8'h7F, 1'b0);
    runTxn("slt_10", 8'h10, 2'b10, 8'hF1, 8'h0F, 1'b1);
    runTxn("sle_smin", 8'h80, 2'b11, 8'h80, 8'h80, 1'b1);
    runTxn("sge_smin", 8'h80, 2'b01, 8'h80, 8'h80, 1'b1);

    // Backpressure: SGE t=0x33 -> x=0xCD, -x=0x33, sat=1, held while out_ready stays low
    applyStimulus(8'h33, 2'b01, lat);
    checkOutput("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_t     = 8'h40 + 8'(i);
      in_mode  = 2'b10;
      step();
      checkOutput($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
      checkOutput($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
      checkOutput($sformatf("bp_x_%0d", i), out_x, 8'hCD);
      checkOutput($sformatf("bp_neg_x_%0d", i), out_neg_x, 8'h33);
      checkOutput($sformatf("bp_sat_%0d", i), out_sat, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_release_ready", in_ready, 1'b1);
    checkOutput("bp_release_valid", out_valid, 1'b0);

    // Reset during the third SHIFT cycle abandons the transaction
    in_t     = 8'h05;
    in_mode  = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("mid_rst_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_x", out_x, 8'h00);
    checkOutput("mid_rst_neg_x", out_neg_x, 8'h00);
    checkOutput("mid_rst_sat", out_sat, 1'b0);
    step();
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen_valid = 1'b1;
      step();
    end
    checkOutput("mid_rst_no_valid", seen_valid, 1'b0);
    runTxn("sge_01", 8'h01, 2'b01, 8'hFF, 8'h01, 1'b1);

    // Exhaustive W=4 sweep
    sweep4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
